// File: rtl/if_id_pipe_reg_pkg.sv
// Shared constants and stage-state encoding for the IF/ID pipeline register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int INS_W_DEF = 32;
    localparam int PC_W_DEF  = 32;

    // sll $0,$0,0 -- the canonical MIPS bubble
    localparam logic [31:0] NOP_CODE = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    // (main_v, skid_v) -> state; the unreachable (0,1) folds into EMPTY,
    // where the skid slot is cleared so the stage cannot lock up.
    function automatic stage_state_t stage_state(input logic main_v, input logic skid_v);
        if (main_v && skid_v)
            return ST_SKID;
        else if (main_v)
            return ST_FULL;
        else
            return ST_EMPTY;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Valid/ready instruction bus between fetch and decode (one instance per side).
// Latency: n/a (wires only).
// Backpressure: ready flows from slave to master.
interface if_id_pipe_reg_if #(
    parameter int INS_W = 32,
    parameter int PC_W  = 32
);
    logic             valid;
    logic             ready;
    logic [INS_W-1:0] ins_code;
    logic [PC_W-1:0]  pc;

    modport master (output valid, output ins_code, output pc, input  ready);
    modport slave  (input  valid, input  ins_code, input  pc, output ready);
endinterface

// File: rtl/if_id_pipe_reg_slot.sv
// One instruction slot: valid flag plus instruction word and PC.
// Latency: loads on the clock edge when load=1; async clear on rst_n.
// Backpressure: none; the owner decides when to load.
module if_id_slot #(
    parameter int INS_W = 32,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             d_valid,
    input  logic [INS_W-1:0] d_ins_code,
    input  logic [PC_W-1:0]  d_pc,
    output logic             q_valid,
    output logic [INS_W-1:0] q_ins_code,
    output logic [PC_W-1:0]  q_pc
);

    // Data only moves with a valid word, so loading an empty slot keeps the old PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid    <= 1'b0;
            q_ins_code <= '0;
            q_pc       <= '0;
        end else if (load) begin
            q_valid <= d_valid;
            if (d_valid) begin
                q_ins_code <= d_ins_code;
                q_pc       <= d_pc;
            end
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with two-entry skid buffer; optional stall counter under IF_ID_STALL_CNT_EN.
// Latency: one cycle from accept to dn_* when the main slot is empty or delivering.
// Backpressure: up.ready is a flop (= ~skid valid), never combinational on dn.ready; flush drops everything.
module if_id_pipe_reg
    import mips_pkg::*;
#(
    parameter int               INS_W    = INS_W_DEF,
    parameter int               PC_W     = PC_W_DEF,
    parameter logic [INS_W-1:0] NOP_CODE = INS_W'(mips_pkg::NOP_CODE)
`ifdef IF_ID_STALL_CNT_EN
    ,
    parameter int               CNT_W    = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    if_id_pipe_reg_if.slave       up,
    if_id_pipe_reg_if.master      dn
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    logic             main_v, skid_v;
    logic [INS_W-1:0] main_ins, skid_ins;
    logic [PC_W-1:0]  main_pc, skid_pc;

    logic             main_load, main_d_valid;
    logic [INS_W-1:0] main_d_ins;
    logic [PC_W-1:0]  main_d_pc;
    logic             skid_load, skid_d_valid;
    logic             next_skid_v;
    logic             rdy_q;
    logic             accept, deliver;
    stage_state_t     state;

    assign accept  = up.valid & rdy_q;
    assign deliver = main_v & dn.ready;

    // Next-slot control: flush wins, otherwise walk EMPTY/FULL/SKID transitions.
    always_comb begin
        state        = stage_state(main_v, skid_v);
        main_load    = 1'b0;
        main_d_valid = 1'b0;
        main_d_ins   = up.ins_code;
        main_d_pc    = up.pc;
        skid_load    = 1'b0;
        skid_d_valid = 1'b0;
        if (flush) begin
            main_load = 1'b1;
            skid_load = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    skid_load = 1'b1;
                    if (accept) begin
                        main_load    = 1'b1;
                        main_d_valid = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        main_load    = 1'b1;
                        main_d_valid = accept;
                    end else if (accept) begin
                        skid_load    = 1'b1;
                        skid_d_valid = 1'b1;
                    end
                end
                ST_SKID: begin
                    // Older skid word always drains into main before anything newer.
                    if (deliver) begin
                        main_load    = 1'b1;
                        main_d_valid = 1'b1;
                        main_d_ins   = skid_ins;
                        main_d_pc    = skid_pc;
                        skid_load    = 1'b1;
                    end
                end
                default: begin
                    main_load = 1'b1;
                    skid_load = 1'b1;
                end
            endcase
        end
        next_skid_v = skid_load ? skid_d_valid : skid_v;
    end

    if_id_slot #(.INS_W(INS_W), .PC_W(PC_W)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (main_load),
        .d_valid    (main_d_valid),
        .d_ins_code (main_d_ins),
        .d_pc       (main_d_pc),
        .q_valid    (main_v),
        .q_ins_code (main_ins),
        .q_pc       (main_pc)
    );

    if_id_slot #(.INS_W(INS_W), .PC_W(PC_W)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .d_valid    (skid_d_valid),
        .d_ins_code (up.ins_code),
        .d_pc       (up.pc),
        .q_valid    (skid_v),
        .q_ins_code (skid_ins),
        .q_pc       (skid_pc)
    );

    // Registered ready: open exactly when the skid slot will be empty next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdy_q <= 1'b1;
        else
            rdy_q <= ~next_skid_v;
    end

    assign up.ready    = rdy_q;
    assign dn.valid    = main_v;
    assign dn.ins_code = main_v ? main_ins : NOP_CODE;
    assign dn.pc       = main_pc;

`ifdef IF_ID_STALL_CNT_EN
    // Saturating count of decode-side stall cycles; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (main_v && !dn.ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed self-checking bench for if_id_pipe_reg.
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
// Stall-counter checks are compiled only with IF_ID_STALL_CNT_EN.
module tb_if_id_pipe_reg;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_errors;

    if_id_pipe_reg_if #(.INS_W(32), .PC_W(32)) up_if ();
    if_id_pipe_reg_if #(.INS_W(32), .PC_W(32)) dn_if ();

`ifdef IF_ID_STALL_CNT_EN
    logic [3:0] stall_cnt;
    if_id_pipe_reg #(.INS_W(32), .PC_W(32), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .up        (up_if),
        .dn        (dn_if),
        .stall_cnt (stall_cnt)
    );
`else
    if_id_pipe_reg #(.INS_W(32), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .up    (up_if),
        .dn    (dn_if)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
        up_if.valid    = v;
        up_if.ins_code = ins;
        up_if.pc       = pc;
        dn_if.ready    = rdy;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);

        // Reset state
        #12;
        chk("rst_dn_valid", dn_if.valid, 1'b0);
        chk("rst_dn_ins",   dn_if.ins_code, 32'h0);
        chk("rst_dn_pc",    dn_if.pc, 32'h0);
        chk("rst_up_ready", up_if.ready, 1'b1);
`ifdef IF_ID_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 4'd0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: streaming, one cycle latency
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h2001_0005, 32'(i * 4), 1'b1);
            tick();
            chk("s1_valid", dn_if.valid, 1'b1);
            chk("s1_ins",   dn_if.ins_code, 32'h2001_0005);
            chk("s1_pc",    dn_if.pc, 32'(i * 4));
            chk("s1_ready", up_if.ready, 1'b1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("s1_drain_valid", dn_if.valid, 1'b0);
        chk("s1_drain_nop",   dn_if.ins_code, 32'h0);
        chk("s1_drain_pc",    dn_if.pc, 32'h8);

        // 2: stall into skid, ordered drain
        drive(1'b1, 32'h8C22_0004, 32'h10, 1'b1);
        tick();
        chk("s2_full_ins", dn_if.ins_code, 32'h8C22_0004);
        drive(1'b1, 32'hAC22_0008, 32'h14, 1'b0);
        tick();
        chk("s2_skid_valid", dn_if.valid, 1'b1);
        chk("s2_skid_ins",   dn_if.ins_code, 32'h8C22_0004);
        chk("s2_skid_pc",    dn_if.pc, 32'h10);
        chk("s2_skid_ready", up_if.ready, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("s2_second_ins", dn_if.ins_code, 32'hAC22_0008);
        chk("s2_second_pc",  dn_if.pc, 32'h14);
        chk("s2_ready_back", up_if.ready, 1'b1);
        tick();
        chk("s2_empty", dn_if.valid, 1'b0);

        // 3: flush while SKID with an incoming word
        drive(1'b1, 32'h0000_0011, 32'h20, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0022, 32'h24, 1'b0);
        tick();
        chk("s3_skid_ready", up_if.ready, 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'h1000_FFFF, 32'h28, 1'b0);
        tick();
        flush = 1'b0;
        chk("s3_valid", dn_if.valid, 1'b0);
        chk("s3_nop",   dn_if.ins_code, 32'h0);
        chk("s3_ready", up_if.ready, 1'b1);
        chk("s3_pc_hold", dn_if.pc, 32'h20);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("s3_dropped_valid", dn_if.valid, 1'b0);
        chk("s3_dropped_ins",   dn_if.ins_code, 32'h0);

        // 4: async reset mid-cycle while SKID
        drive(1'b1, 32'h0000_0033, 32'h30, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0044, 32'h34, 1'b0);
        tick();
        chk("s4_skid_ready", up_if.ready, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s4_valid", dn_if.valid, 1'b0);
        chk("s4_nop",   dn_if.ins_code, 32'h0);
        chk("s4_ready", up_if.ready, 1'b1);
        chk("s4_pc",    dn_if.pc, 32'h0);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("s4_post_valid", dn_if.valid, 1'b0);
        chk("s4_post_ins",   dn_if.ins_code, 32'h0);

        // 5: back-to-back deliver+accept in FULL
        drive(1'b1, 32'hA000_0000, 32'h100, 1'b1);
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 32'h100 + 32'(i * 4), 1'b1);
            tick();
            chk("s5_valid", dn_if.valid, 1'b1);
            chk("s5_ins",   dn_if.ins_code, 32'hA000_0000 + 32'(i));
            chk("s5_ready", up_if.ready, 1'b1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("s5_drain", dn_if.valid, 1'b0);

`ifdef IF_ID_STALL_CNT_EN
        // 6: stall counter saturates at 15, survives flush
        drive(1'b1, 32'h0000_0055, 32'h40, 1'b0);
        tick();
        chk("s6_cnt_start", stall_cnt, 4'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 4)
                chk("s6_cnt_mid", stall_cnt, 4'd5);
        end
        chk("s6_cnt_sat", stall_cnt, 4'd15);
        chk("s6_still_valid", dn_if.valid, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s6_cnt_flush", stall_cnt, 4'd15);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
